// File: rtl/filter_arb_pkg.sv
// Shared types and geometry for the filter frame write arbiter.
package filter_arb_pkg;

  localparam int N_REQ        = 4;
  localparam int PIX_W        = 7;
  localparam int FRAME_W      = 240;
  localparam int FRAME_H      = 320;
  localparam int FIFO_DEPTH   = 4;
  localparam int ADDR_W       = 19;
  localparam int LADDR_W      = 17;
  localparam int IDX_W        = $clog2(N_REQ);
  localparam int FRAME_PIXELS = FRAME_W * FRAME_H;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_STOPPING,
    ST_FROZEN,
    ST_ARMING
  } freeze_state_t;

  typedef struct packed {
    logic [LADDR_W-1:0] local_addr;
    logic [PIX_W-1:0]   pixel;
  } fifo_entry_t;

  function automatic logic [LADDR_W-1:0] calc_local_addr(input logic [9:0]  vcount,
                                                         input logic [10:0] hcount);
    return LADDR_W'(vcount) * LADDR_W'(FRAME_W) + LADDR_W'(hcount);
  endfunction

endpackage

// File: rtl/arb_fifo.sv
// Small synchronous FIFO holding one stream's pending pixels; a push into a
// full FIFO is still taken when the same cycle pops it.
module arb_fifo
  import filter_arb_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        push,
  input  logic        pop,
  input  fifo_entry_t din,
  output fifo_entry_t dout,
  output logic        full,
  output logic        empty
);

  localparam int PTR_W = $clog2(DEPTH);

  fifo_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers make stale entries unreachable.
  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/filter_frame_write_arbiter.sv
// Shares one BRAM write port among N_REQ filter streams with per-stream FIFOs,
// round-robin grant, stacked-frame addressing and frame-aligned freeze.
module filter_frame_write_arbiter
  import filter_arb_pkg::*;
(
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         freeze_in,
  input  logic [N_REQ-1:0]             req_valid_in,
  input  logic [N_REQ-1:0][10:0]       req_hcount_in,
  input  logic [N_REQ-1:0][9:0]        req_vcount_in,
  input  logic [N_REQ-1:0][PIX_W-1:0]  req_pixel_in,
  output logic                         wr_en_out,
  output logic [ADDR_W-1:0]            wr_addr_out,
  output logic [PIX_W-1:0]             wr_data_out,
  output logic [N_REQ-1:0]             grant_out,
  output logic [N_REQ-1:0]             overflow_out,
  output logic                         frozen_out
);

  freeze_state_t    state, state_nxt;
  logic [N_REQ-1:0] attempt, pop, full, empty, blocked, is_first, is_last;
  fifo_entry_t      din  [N_REQ];
  fifo_entry_t      dout [N_REQ];
  logic [IDX_W-1:0] rr, gidx, cand;
  logic             gvalid;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    attempt  = '0;
    is_first = '0;
    is_last  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      din[i] = '{local_addr: calc_local_addr(req_vcount_in[i], req_hcount_in[i]),
                 pixel:      req_pixel_in[i]};
      is_first[i] = (req_hcount_in[i] == 11'd0) && (req_vcount_in[i] == 10'd0);
      is_last[i]  = (req_hcount_in[i] == 11'(FRAME_W-1)) && (req_vcount_in[i] == 10'(FRAME_H-1));
      if (req_valid_in[i] && (req_hcount_in[i] < 11'(FRAME_W)) && (req_vcount_in[i] < 10'(FRAME_H)))
        attempt[i] = blocked[i] ? (state == ST_ARMING && is_first[i]) : (state != ST_FROZEN);
    end
  end

  for (genvar i = 0; i < N_REQ; i++) begin : g_fifo
    arb_fifo u_fifo (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .push   (attempt[i]),
      .pop    (pop[i]),
      .din    (din[i]),
      .dout   (dout[i]),
      .full   (full[i]),
      .empty  (empty[i])
    );
  end

  // Search starts just after the last winner so every stream gets a turn.
  always_comb begin
    gvalid = 1'b0;
    gidx   = rr;
    cand   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(rr) + k) % N_REQ);
      if (!gvalid && !empty[cand]) begin
        gvalid = 1'b1;
        gidx   = cand;
      end
    end
    pop = '0;
    if (gvalid) pop[gidx] = 1'b1;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rr           <= IDX_W'(N_REQ-1);
      wr_en_out    <= 1'b0;
      wr_addr_out  <= '0;
      wr_data_out  <= '0;
      grant_out    <= '0;
      overflow_out <= '0;
    end else begin
      overflow_out <= overflow_out | (attempt & full & ~pop);
      wr_en_out    <= gvalid;
      grant_out    <= pop;
      if (gvalid) begin
        rr          <= gidx;
        wr_addr_out <= ADDR_W'(gidx) * ADDR_W'(FRAME_PIXELS) + ADDR_W'(dout[gidx].local_addr);
        wr_data_out <= dout[gidx].pixel;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state   <= ST_RUN;
      blocked <= '0;
    end else begin
      state <= state_nxt;
      for (int i = 0; i < N_REQ; i++) begin
        if (attempt[i] && state == ST_STOPPING && is_last[i]) blocked[i] <= 1'b1;
        else if (attempt[i] && blocked[i])                    blocked[i] <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:      if (freeze_in) state_nxt = ST_STOPPING;
      ST_STOPPING: if (!freeze_in)                  state_nxt = ST_ARMING;
                   else if (&blocked && &empty)     state_nxt = ST_FROZEN;
      ST_FROZEN:   if (!freeze_in) state_nxt = ST_ARMING;
      ST_ARMING:   if (freeze_in)                   state_nxt = ST_STOPPING;
                   else if (blocked == '0)          state_nxt = ST_RUN;
      default:     state_nxt = ST_RUN;
    endcase
  end

  assign frozen_out = (state == ST_FROZEN);

endmodule

// File: tb/tb_filter_frame_write_arbiter.sv
// Randomised and directed bench for the frame write arbiter against a queue-based model.
module tb_filter_frame_write_arbiter;
  import filter_arb_pkg::*;

  logic                        clk_in = 1'b0;
  logic                        rst_in = 1'b1;
  logic                        freeze_in = 1'b0;
  logic [N_REQ-1:0]            req_valid_in = '0;
  logic [N_REQ-1:0][10:0]      req_hcount_in = '0;
  logic [N_REQ-1:0][9:0]       req_vcount_in = '0;
  logic [N_REQ-1:0][PIX_W-1:0] req_pixel_in = '0;
  logic                        wr_en_out;
  logic [ADDR_W-1:0]           wr_addr_out;
  logic [PIX_W-1:0]            wr_data_out;
  logic [N_REQ-1:0]            grant_out;
  logic [N_REQ-1:0]            overflow_out;
  logic                        frozen_out;

  filter_frame_write_arbiter dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .freeze_in     (freeze_in),
    .req_valid_in  (req_valid_in),
    .req_hcount_in (req_hcount_in),
    .req_vcount_in (req_vcount_in),
    .req_pixel_in  (req_pixel_in),
    .wr_en_out     (wr_en_out),
    .wr_addr_out   (wr_addr_out),
    .wr_data_out   (wr_data_out),
    .grant_out     (grant_out),
    .overflow_out  (overflow_out),
    .frozen_out    (frozen_out)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: one queue of pending (absolute address, pixel) per stream.
  int qa [N_REQ][$];
  int qd [N_REQ][$];
  int m_rr;
  bit mblocked [N_REQ];
  bit m_stopping, m_arming;
  logic              exp_en;
  logic [ADDR_W-1:0] exp_addr;
  logic [PIX_W-1:0]  exp_data;
  logic [N_REQ-1:0]  exp_grant, exp_ovf;
  int tests = 0;
  int failed = 0;

  function automatic logic [34:0] dut_vec();
    return {wr_en_out, wr_addr_out, wr_data_out, grant_out, overflow_out};
  endfunction

  function automatic logic [34:0] exp_vec();
    return {exp_en, exp_addr, exp_data, exp_grant, exp_ovf};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_REQ; i++) begin
      qa[i].delete();
      qd[i].delete();
      mblocked[i] = 1'b0;
    end
    m_rr = N_REQ - 1;
    m_stopping = 1'b0;
    m_arming = 1'b0;
    exp_en = 1'b0;
    exp_addr = '0;
    exp_data = '0;
    exp_grant = '0;
    exp_ovf = '0;
  endtask

  task automatic drive(input int s, input int h, input int v, input int pix);
    req_valid_in[s]  = 1'b1;
    req_hcount_in[s] = 11'(h);
    req_vcount_in[s] = 10'(v);
    req_pixel_in[s]  = 7'(pix);
  endtask

  // Predicts this edge's effect from the current inputs, then advances one cycle.
  task automatic step();
    int g, h, v;
    bit ok, was;
    g = -1;
    for (int k = 1; k <= N_REQ; k++)
      if (g < 0 && qa[(m_rr + k) % N_REQ].size() > 0) g = (m_rr + k) % N_REQ;
    if (g >= 0) begin
      exp_en = 1'b1;
      exp_addr = ADDR_W'(qa[g].pop_front());
      exp_data = PIX_W'(qd[g].pop_front());
      exp_grant = 4'(1 << g);
      m_rr = g;
    end else begin
      exp_en = 1'b0;
      exp_grant = '0;
    end
    for (int i = 0; i < N_REQ; i++) begin
      h = int'(req_hcount_in[i]);
      v = int'(req_vcount_in[i]);
      if (req_valid_in[i] && h < FRAME_W && v < FRAME_H) begin
        was = mblocked[i];
        ok = !was || (m_arming && h == 0 && v == 0);
        if (was && ok) mblocked[i] = 1'b0;
        if (ok) begin
          if (qa[i].size() < FIFO_DEPTH) begin
            qa[i].push_back(i * FRAME_PIXELS + v * FRAME_W + h);
            qd[i].push_back(int'(req_pixel_in[i]));
          end else begin
            exp_ovf[i] = 1'b1;
          end
          if (!was && m_stopping && h == FRAME_W - 1 && v == FRAME_H - 1) mblocked[i] = 1'b1;
        end
      end
    end
    @(posedge clk_in);
    #1;
    req_valid_in = '0;
  endtask

  task automatic apply_reset();
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk_in);
    #1;
    tests++;
    if (dut_vec() !== 35'd0 || frozen_out !== 1'b0) begin
      failed++;
      $display("FAIL reset_state: got %h frozen=%b, want 0", dut_vec(), frozen_out);
    end
    rst_in = 1'b0;
    model_reset();
    repeat (3) begin
      step();
      tests++;
      if (dut_vec() !== exp_vec()) begin
        failed++;
        $display("FAIL reset_idle: got %h, want %h", dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_single();
    drive(2, 5, 1, 'h3A);
    for (int c = 0; c < 3; c++) begin
      step();
      tests++;
      if (dut_vec() !== exp_vec()) begin
        failed++;
        $display("FAIL single_model c%0d: got %h, want %h", c, dut_vec(), exp_vec());
      end
      if (c == 1) begin
        tests++;
        if (!(wr_en_out === 1'b1 && wr_addr_out === 19'd153845 && wr_data_out === 7'h3A &&
              grant_out === 4'b0100)) begin
          failed++;
          $display("FAIL single_write: got en=%b addr=%0d data=%h grant=%b, want 1 153845 3a 0100",
                   wr_en_out, wr_addr_out, wr_data_out, grant_out);
        end
      end
    end
  endtask

  task automatic test_all_four();
    logic [N_REQ-1:0] want_g;
    apply_reset();
    for (int i = 0; i < N_REQ; i++)
      drive(i, $urandom_range(0, FRAME_W - 1), $urandom_range(0, FRAME_H - 1), $urandom_range(0, 127));
    step();
    for (int k = 0; k < N_REQ; k++) begin
      step();
      want_g = 4'(1 << k);
      tests++;
      if (dut_vec() !== exp_vec() || grant_out !== want_g) begin
        failed++;
        $display("FAIL all_four k%0d: got %h grant=%b, want %h grant=%b",
                 k, dut_vec(), grant_out, exp_vec(), want_g);
      end
    end
    tests++;
    if (overflow_out !== 4'b0000) begin
      failed++;
      $display("FAIL all_four_ovf: got %b, want 0000", overflow_out);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int c = 0; c < 14; c++) begin
      if (c < 6)
        for (int i = 0; i < N_REQ; i++)
          drive(i, (i == 1) ? c : $urandom_range(0, FRAME_W - 1), $urandom_range(0, FRAME_H - 1),
                $urandom_range(0, 127));
      step();
      tests++;
      if (dut_vec() !== exp_vec()) begin
        failed++;
        $display("FAIL overflow_model c%0d: got %h, want %h", c, dut_vec(), exp_vec());
      end
    end
    tests++;
    if (overflow_out[1] !== 1'b1) begin
      failed++;
      $display("FAIL overflow_stream1: got %b, want 1", overflow_out[1]);
    end
  endtask

  task automatic test_out_of_range();
    logic [N_REQ-1:0] ovf_before;
    apply_reset();
    ovf_before = overflow_out;
    for (int c = 0; c < 3; c++) begin
      drive(3, FRAME_W, 0, 1);
      drive(0, 0, FRAME_H, 2);
      drive(1, 2047, 1023, 3);
      step();
      tests++;
      if (dut_vec() !== exp_vec() || wr_en_out !== 1'b0 || overflow_out !== ovf_before) begin
        failed++;
        $display("FAIL out_of_range c%0d: got %h, want %h", c, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_freeze();
    apply_reset();
    freeze_in = 1'b1;
    step();
    m_stopping = 1'b1;
    for (int c = 0; c < 12; c++) begin
      case (c)
        0: begin drive(1, 100, 200, 'h21); drive(0, 238, 319, 'h22); end
        1: drive(0, 239, 319, 'h23);
        2: drive(0, 0, 0, 'h24);
        3: for (int i = 1; i < N_REQ; i++) drive(i, 239, 319, 'h30 + i);
        10: drive(2, 0, 0, 'h25);
        default: ;
      endcase
      step();
      tests++;
      if (dut_vec() !== exp_vec()) begin
        failed++;
        $display("FAIL freeze_model c%0d: got %h, want %h", c, dut_vec(), exp_vec());
      end
      if (c == 2) begin
        tests++;
        if (frozen_out !== 1'b0) begin
          failed++;
          $display("FAIL freeze_early: got %b, want 0", frozen_out);
        end
      end
    end
    tests++;
    if (frozen_out !== 1'b1) begin
      failed++;
      $display("FAIL frozen_set: got %b, want 1", frozen_out);
    end
    freeze_in = 1'b0;
    step();
    m_stopping = 1'b0;
    m_arming = 1'b1;
    tests++;
    if (frozen_out !== 1'b0) begin
      failed++;
      $display("FAIL frozen_release: got %b, want 0", frozen_out);
    end
    for (int c = 0; c < 10; c++) begin
      case (c)
        0: drive(0, 5, 0, 'h40);
        1: drive(0, 0, 0, 'h41);
        3: for (int i = 1; i < N_REQ; i++) drive(i, 0, 0, 'h50 + i);
        8: drive(3, 1, 0, 'h60);
        default: ;
      endcase
      if (c == 7) m_arming = 1'b0;
      step();
      tests++;
      if (dut_vec() !== exp_vec()) begin
        failed++;
        $display("FAIL arm_model c%0d: got %h, want %h", c, dut_vec(), exp_vec());
      end
      if (c == 2) begin
        tests++;
        if (!(wr_en_out === 1'b1 && wr_addr_out === 19'd0 && wr_data_out === 7'h41 &&
              grant_out === 4'b0001)) begin
          failed++;
          $display("FAIL arm_first_write: got en=%b addr=%0d data=%h grant=%b, want 1 0 41 0001",
                   wr_en_out, wr_addr_out, wr_data_out, grant_out);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int writes;
    apply_reset();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < N_REQ; i++)
        drive(i, $urandom_range(0, FRAME_W - 1), $urandom_range(0, FRAME_H - 1), $urandom_range(0, 127));
      step();
    end
    #2 rst_in = 1'b1;
    #1;
    tests++;
    if (dut_vec() !== 35'd0 || frozen_out !== 1'b0) begin
      failed++;
      $display("FAIL reset_mid_async: got %h, want 0", dut_vec());
    end
    model_reset();
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    writes = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (wr_en_out === 1'b1) writes++;
      tests++;
      if (dut_vec() !== exp_vec()) begin
        failed++;
        $display("FAIL reset_mid_model c%0d: got %h, want %h", c, dut_vec(), exp_vec());
      end
    end
    tests++;
    if (writes != 0) begin
      failed++;
      $display("FAIL reset_mid_stale: got %0d writes, want 0", writes);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      if (c < 590)
        for (int i = 0; i < N_REQ; i++)
          if ($urandom_range(0, 4) == 0)
            drive(i, $urandom_range(0, FRAME_W), $urandom_range(0, FRAME_H), $urandom_range(0, 127));
      step();
      tests++;
      if (dut_vec() !== exp_vec()) begin
        failed++;
        $display("FAIL random_model c%0d: got %h, want %h", c, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_overflow();
    test_out_of_range();
    test_freeze();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
